countdown: RTL and testbench
============================

COUNTDOWN -- requirements
Module: countdown

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, clk cycles per 1 s tick.
REQ-002 SHALL have parameter SCAN_DIV, default 100_000, clk cycles per display digit slot.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  run/pause/acknowledge button, level, synchronous to clk.
REQ-006 SHALL have port set_min  input  1  minute-increment button, level.
REQ-007 SHALL have port set_sec  input  1  second-increment button, level.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, common anode.
REQ-009 SHALL have port AN  output  4  digit enables, active-low, AN[0]=seconds ones ... AN[3]=minutes tens.
REQ-010 SHALL have port alarm  output  1  high while timer expired.

Function
REQ-011 SHALL rising-edge-detect start, set_min and set_sec internally: one action per 0->1 transition, regardless of hold time.
REQ-012 SHALL hold time as four BCD digits MM:SS, range 00:00-99:59.
REQ-013 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-014 IDLE: set_min edge increments minutes 00->99 and wraps 99->00; set_sec edge increments seconds 00->59 and wraps 59->00; the other field is unchanged.
REQ-015 IDLE: start edge with time != 00:00 -> RUN with tick counter cleared; with time == 00:00 it SHALL be ignored.
REQ-016 IDLE: start and a set edge in the same cycle -> start wins; the set edge is discarded.
REQ-017 RUN: tick counter counts 0..CLK_HZ-1; on reaching CLK_HZ-1 it wraps and time decrements by one second with BCD borrow (e.g. 10:00 -> 09:59).
REQ-018 RUN: the tick that makes time 00:00 SHALL, on the same edge, enter DONE and set alarm=1.
REQ-019 RUN: start edge -> PAUSE; time and tick counter frozen; a tick coinciding with that edge SHALL NOT decrement.
REQ-020 PAUSE: start edge -> RUN, tick counter resumes from its held value; set edges are ignored.
REQ-021 DONE: start edge -> IDLE, alarm=0, time stays 00:00; set edges are ignored.
REQ-022 RUN, PAUSE and DONE SHALL ignore set_min and set_sec.
REQ-023 Scan: digit slot advances every SCAN_DIV cycles in order AN[0],AN[1],AN[2],AN[3],AN[0]; exactly one AN bit low at a time; scanning runs in all states.
REQ-024 seg SHALL decode the selected BCD digit, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-025 seg and AN SHALL be registered; they change together on the edge the slot advances.

Reset
REQ-026 reset=0 at a rising clk edge SHALL force: state IDLE, time 00:00, alarm=0, tick and scan counters 0, edge-detector history 0, AN=1110, seg=1000000.
REQ-027 Reset SHALL take priority over every other input in any state, including mid-RUN and DONE.

Configuration
REQ-028 With macro COUNTDOWN_BLINK_EN defined, in DONE the tick counter SHALL keep running and AN SHALL be forced to 1111 while tick counter >= CLK_HZ/2, with the normal scan otherwise.
REQ-029 Without COUNTDOWN_BLINK_EN, DONE SHALL display 00:00 steadily with normal scanning; alarm behaviour is identical in both builds.

Verification (CLK_HZ=10, SCAN_DIV=2)
REQ-030 reset=0 for 2 cycles -> AN=1110, seg=1000000, alarm=0; set_min held high for 50 cycles -> minutes=01 (single increment).
REQ-031 In IDLE, 100 set_min pulses -> minutes wrap to 00; 60 set_sec pulses -> seconds wrap to 00.
REQ-032 Time 01:00, start pulse -> after 10 cycles time 00:59; scanned digits read 9,5,0,0 on AN[0..3].
REQ-033 Time 00:02, start pulse -> alarm rises exactly 20 cycles after RUN entry; start pulse -> alarm=0, IDLE.
REQ-034 RUN at 00:05, start pulse at tick cycle 7 -> frozen 30 cycles; start pulse -> next decrement 3 cycles later.
REQ-035 In RUN, reset=0 for 1 cycle -> IDLE, 00:00, alarm=0; with COUNTDOWN_BLINK_EN, DONE shows AN=1111 for cycles 5-9 of each tick period.

Source files
------------

// File: rtl/countdown.sv
// countdown: MM:SS BCD countdown timer with a multiplexed 4-digit common-anode display.
// Optional build macro COUNTDOWN_BLINK_EN blanks the display for the second half of each tick while in DONE.
module countdown #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       set_min,
    input  logic       set_sec,
    output logic [6:0] seg,
    output logic [3:0] AN,
    output logic       alarm
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(CLK_HZ - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] tick_inc;
    logic [3:0]        min_t, min_o, sec_t, sec_o;
    logic              start_q, min_q, sec_q;
    logic              start_edge, min_edge, sec_edge;
    logic              time_zero, time_one, tick_last;
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        slot, slot_next, slot_sel;
    logic              slot_adv, blank_d;
    logic [3:0]        digit_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign start_edge = start & ~start_q;
    assign min_edge   = set_min & ~min_q;
    assign sec_edge   = set_sec & ~sec_q;
    assign time_zero  = ({min_t, min_o, sec_t, sec_o} == 16'h0000);
    assign time_one   = ({min_t, min_o, sec_t, sec_o} == 16'h0001);
    assign tick_last  = (tick == TICK_MAX);
    assign tick_inc   = tick_last ? '0 : tick + TICK_W'(1);

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_q <= 1'b0;
            min_q   <= 1'b0;
            sec_q   <= 1'b0;
        end else begin
            start_q <= start;
            min_q   <= set_min;
            sec_q   <= set_sec;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            tick  <= '0;
            min_t <= 4'd0;
            min_o <= 4'd0;
            sec_t <= 4'd0;
            sec_o <= 4'd0;
            alarm <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A start edge swallows any set edge arriving with it, even when start is ignored.
                    if (start_edge) begin
                        if (!time_zero) begin
                            state <= RUN;
                            tick  <= '0;
                        end
                    end else begin
                        if (min_edge) begin
                            if (min_o == 4'd9) begin
                                min_o <= 4'd0;
                                min_t <= (min_t == 4'd9) ? 4'd0 : min_t + 4'd1;
                            end else begin
                                min_o <= min_o + 4'd1;
                            end
                        end
                        if (sec_edge) begin
                            if (sec_o == 4'd9) begin
                                sec_o <= 4'd0;
                                sec_t <= (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
                            end else begin
                                sec_o <= sec_o + 4'd1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (start_edge) begin
                        state <= PAUSE;
                    end else if (tick_last) begin
                        tick <= '0;
                        // BCD borrow chain; time is never 00:00 here so min_t cannot underflow.
                        if (sec_o != 4'd0) begin
                            sec_o <= sec_o - 4'd1;
                        end else begin
                            sec_o <= 4'd9;
                            if (sec_t != 4'd0) begin
                                sec_t <= sec_t - 4'd1;
                            end else begin
                                sec_t <= 4'd5;
                                if (min_o != 4'd0) begin
                                    min_o <= min_o - 4'd1;
                                end else begin
                                    min_o <= 4'd9;
                                    min_t <= min_t - 4'd1;
                                end
                            end
                        end
                        if (time_one) begin
                            state <= DONE;
                            alarm <= 1'b1;
                        end
                    end else begin
                        tick <= tick_inc;
                    end
                end
                PAUSE: begin
                    if (start_edge) state <= RUN;
                end
                DONE: begin
                    if (start_edge) begin
                        state <= IDLE;
                        alarm <= 1'b0;
                        tick  <= '0;
                    end
`ifdef COUNTDOWN_BLINK_EN
                    else begin
                        tick <= tick_inc;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the default arm keeps digit_next assigned on every path, so no latch is inferred.
    always_comb begin
        slot_adv  = (scan_cnt == SCAN_MAX);
        slot_next = slot + 2'd1;
        slot_sel  = slot_adv ? slot_next : slot;
        case (slot_next)
            2'd0:    digit_next = sec_o;
            2'd1:    digit_next = sec_t;
            2'd2:    digit_next = min_o;
            default: digit_next = min_t;
        endcase
    end

`ifdef COUNTDOWN_BLINK_EN
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CLK_HZ / 2);
    // Looks at the tick value being loaded this edge so the registered AN lines up with it.
    assign blank_d = (state == DONE) && !start_edge && (tick_inc >= TICK_HALF);
`else
    assign blank_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            scan_cnt <= '0;
            slot     <= 2'd0;
            seg      <= 7'b1000000;
            AN       <= 4'b1110;
        end else begin
            if (slot_adv) begin
                scan_cnt <= '0;
                slot     <= slot_next;
                seg      <= seg_decode(digit_next);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            AN <= blank_d ? 4'b1111 : ~(4'b0001 << slot_sel);
        end
    end

endmodule

// File: tb/tb_countdown.sv
// tb_countdown: scoreboard bench for countdown; a time/second-level reference model queues the expected
// {AN, seg, alarm} each edge and a monitor compares them, alongside directed display and timing checks.
module tb_countdown;

    localparam int CLK_HZ   = 10;
    localparam int SCAN_DIV = 2;
`ifdef COUNTDOWN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       start   = 1'b0;
    logic       set_min = 1'b0;
    logic       set_sec = 1'b0;
    logic [6:0] seg;
    logic [3:0] AN;
    logic       alarm;

    countdown #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .set_min(set_min),
        .set_sec(set_sec),
        .seg    (seg),
        .AN     (AN),
        .alarm  (alarm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference model: time kept as integer minutes/seconds, scan position derived from edges since reset.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       alarm;
    } obs_t;

    mstate_t    m_state = M_IDLE;
    int         m_min = 0, m_sec = 0, m_tick = 0, m_k = 0;
    bit         m_alarm = 0, m_valid = 0;
    bit         h_start = 0, h_min = 0, h_sec = 0;
    logic [6:0] m_seg = 7'b1000000;
    logic [3:0] m_an = 4'b1110;
    obs_t       exp_q[$];

    function automatic int digit_of(input int slot, input int mn, input int sc);
        case (slot)
            0:       return sc % 10;
            1:       return sc / 10;
            2:       return mn % 10;
            default: return mn / 10;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_state = M_IDLE; m_min = 0; m_sec = 0; m_tick = 0; m_k = 0; m_alarm = 0;
            h_start = 0; h_min = 0; h_sec = 0;
            m_seg = seg_tab[0]; m_an = 4'b1110; m_valid = 1;
        end else if (m_valid) begin
            bit se, me, ce, blank;
            int slot, total;
            se = start && !h_start; me = set_min && !h_min; ce = set_sec && !h_sec;
            h_start = start; h_min = set_min; h_sec = set_sec;
            m_k++;
            slot = (m_k / SCAN_DIV) % 4;
            if (m_k % SCAN_DIV == 0) m_seg = seg_tab[digit_of(slot, m_min, m_sec)];
            case (m_state)
                M_IDLE: begin
                    if (se) begin
                        if (m_min != 0 || m_sec != 0) begin m_state = M_RUN; m_tick = 0; end
                    end else begin
                        if (me) m_min = (m_min + 1) % 100;
                        if (ce) m_sec = (m_sec + 1) % 60;
                    end
                end
                M_RUN: begin
                    if (se) m_state = M_PAUSE;
                    else if (m_tick == CLK_HZ - 1) begin
                        m_tick = 0;
                        total = m_min * 60 + m_sec - 1;
                        m_min = total / 60; m_sec = total % 60;
                        if (total == 0) begin m_state = M_DONE; m_alarm = 1; end
                    end else m_tick++;
                end
                M_PAUSE: if (se) m_state = M_RUN;
                default: begin
                    if (se) begin m_state = M_IDLE; m_alarm = 0; m_tick = 0; end
                    else if (BLINK) m_tick = (m_tick + 1) % CLK_HZ;
                end
            endcase
            blank = BLINK && (m_state == M_DONE) && (m_tick >= CLK_HZ / 2);
            m_an = blank ? 4'b1111 : ~(4'b0001 << slot);
        end
        if (m_valid) begin
            obs_t o;
            o.an = m_an; o.seg = m_seg; o.alarm = m_alarm;
            exp_q.push_back(o);
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check("outputs{AN,seg,alarm}", {20'b0, AN, seg, alarm}, {20'b0, e});
        end
    end

    logic [6:0] cap [4];

    task automatic capture_round();
        logic [3:0] prev, onehot;
        for (int s = 0; s < 4; s++) cap[s] = 7'bx;
        prev = AN;
        for (int i = 0; i < 4 * SCAN_DIV; i++) begin
            @(negedge clk);
            if (AN !== prev) begin
                for (int s = 0; s < 4; s++) begin
                    onehot = ~(4'b0001 << s);
                    if (AN === onehot) cap[s] = seg;
                end
            end
            prev = AN;
        end
    endtask

    task automatic check_digits(input string name, input int d3, input int d2, input int d1, input int d0);
        capture_round();
        check({name, "_AN0"}, cap[0], seg_tab[d0]);
        check({name, "_AN1"}, cap[1], seg_tab[d1]);
        check({name, "_AN2"}, cap[2], seg_tab[d2]);
        check({name, "_AN3"}, cap[3], seg_tab[d3]);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        start = 0; set_min = 0; set_sec = 0; reset = 0;
        repeat (n) @(negedge clk);
        reset = 1;
    endtask

    task automatic press_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic press_min();
        @(negedge clk) set_min = 1;
        @(negedge clk) set_min = 0;
    endtask

    task automatic press_sec();
        @(negedge clk) set_sec = 1;
        @(negedge clk) set_sec = 0;
    endtask

    initial begin
        int n, blanks;
        repeat (2) @(negedge clk);
        check("rst_AN", AN, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_alarm", alarm, 1'b0);
        reset = 1;

        // Held button acts once.
        set_min = 1;
        repeat (50) @(negedge clk);
        set_min = 0;
        check_digits("hold_min", 0, 1, 0, 0);

        // Minute and second wrap boundaries.
        do_reset(1);
        repeat (99) press_min();
        check_digits("min_99", 9, 9, 0, 0);
        press_min();
        check_digits("min_wrap", 0, 0, 0, 0);
        repeat (37) press_sec();
        check_digits("sec_37", 0, 0, 3, 7);
        repeat (23) press_sec();
        check_digits("sec_wrap", 0, 0, 0, 0);

        // 01:00 -> 00:59 after one tick period.
        do_reset(1);
        press_min();
        press_start();
        repeat (10) @(negedge clk);
        check_digits("run_0059", 0, 0, 5, 9);

        // 00:02 -> alarm exactly 20 cycles after RUN entry.
        do_reset(1);
        repeat (2) press_sec();
        press_start();
        n = 0;
        while (alarm !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("alarm_latency", n, 20);
        press_min();
        blanks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (AN === 4'b1111) blanks++;
        end
        check("done_blank_cycles", blanks, BLINK ? 20'd10 : 20'd0);
        press_start();
        check("alarm_clear", alarm, 1'b0);
        press_sec();
        check_digits("done_to_idle", 0, 0, 0, 1);

        // Pause at tick 7, hold 30 cycles, resume, decrement 3 cycles later.
        do_reset(1);
        repeat (5) press_sec();
        press_start();
        repeat (6) @(negedge clk);
        press_start();
        repeat (22) @(negedge clk);
        check_digits("paused_0005", 0, 0, 0, 5);
        press_start();
        repeat (3) @(negedge clk);
        check_digits("resumed_0004", 0, 0, 0, 4);

        // Start and set on the same edge: start wins; set ignored in PAUSE.
        do_reset(1);
        repeat (3) press_sec();
        @(negedge clk) begin start = 1; set_min = 1; end
        @(negedge clk) begin start = 0; set_min = 0; end
        press_start();
        check_digits("start_wins", 0, 0, 0, 3);
        press_min();
        check_digits("pause_ignores_set", 0, 0, 0, 3);

        // Reset mid-RUN; start at 00:00 ignored.
        do_reset(1);
        press_min();
        press_start();
        repeat (15) @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        check("run_rst_AN", AN, 4'b1110);
        check("run_rst_seg", seg, 7'b1000000);
        check("run_rst_alarm", alarm, 1'b0);
        press_start();
        check_digits("zero_start_ignored", 0, 0, 0, 0);

        // Randomized episodes, checked by the scoreboard.
        for (int ep = 0; ep < 20; ep++) begin
            do_reset(1);
            repeat ($urandom_range(1, 6)) press_sec();
            if ($urandom_range(0, 3) == 0) press_min();
            press_start();
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                start   = ($urandom_range(0, 39) == 0);
                set_min = ($urandom_range(0, 9) == 0);
                set_sec = ($urandom_range(0, 5) == 0);
                reset   = ($urandom_range(0, 299) != 0);
            end
            start = 0; set_min = 0; set_sec = 0; reset = 1;
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
